// File: rtl/pulse_measure_pkg.sv
// Shared types for the pulse measurement block: control strobes, result record, FSM states.
package pulse_measure_pkg;

   // Width of the result fields. Instances may use a narrower counter; results are zero-extended.
   localparam int CNT_W_DEFAULT = 32;

   typedef struct packed {
      logic rising;
      logic falling;
   } control_path_t;

   typedef struct packed {
      logic [CNT_W_DEFAULT-1:0] period;
      logic [CNT_W_DEFAULT-1:0] high_time;
      logic                     timeout;
      logic                     saturated;
   } measurement_t;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } meas_state_t;

   // Assemble a result record from its fields.
   function automatic measurement_t make_meas(
      input logic [CNT_W_DEFAULT-1:0] period,
      input logic [CNT_W_DEFAULT-1:0] high_time,
      input logic                     timeout,
      input logic                     saturated
   );
      measurement_t m;
      m.period    = period;
      m.high_time = high_time;
      m.timeout   = timeout;
      m.saturated = saturated;
      return m;
   endfunction

endpackage

// File: rtl/pulse_measure_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats enable, counting stops at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_enable,
   output logic [W-1:0] o_count,
   output logic         o_at_max
);

   localparam logic [W-1:0] MAX_VAL = '1;

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign o_count  = count_q;
   assign o_at_max = (count_q == MAX_VAL);

   // Next count: clear first, otherwise increment unless already pinned at the maximum.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable && !o_at_max) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pulse_measure.sv
// Measures period and high time (in ticks) between rising edges and hands each result
// to a one-deep valid/ready output register.
module pulse_measure
   import pulse_measure_pkg::*;
#(
   parameter int          CNT_W         = CNT_W_DEFAULT,
   parameter int unsigned TIMEOUT_TICKS = 1000000
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  control_path_t i_control,
   input  logic          i_count_enable,
   output measurement_t  o_result,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_overrun,
   output logic          o_busy
);

   localparam logic [CNT_W_DEFAULT-1:0] TIMEOUT_VAL = TIMEOUT_TICKS;

   meas_state_t  state_q, state_d;
   logic         high_open_q, high_open_d;
   logic         sat_q, sat_d;
   measurement_t result_q, result_d;
   logic         valid_q, valid_d;
   logic         overrun_q, overrun_d;

   logic [CNT_W-1:0]         period_cnt, high_cnt;
   logic                     period_at_max, high_at_max;
   logic [CNT_W_DEFAULT-1:0] period_ext, high_ext;
   logic                     in_measure, timeout_hit, capture;
   logic                     cnt_clear, period_en, high_en;
   measurement_t             cap_val;

   // A rising edge takes priority over a coincident tick, so that tick is dropped from both
   // the closing and the new measurement. Timeout is checked on the cycle after the tick
   // that brought the period up to the limit.
   assign in_measure  = (state_q == MEASURE);
   assign timeout_hit = in_measure && !i_control.rising && (period_ext == TIMEOUT_VAL);
   assign capture     = (in_measure && i_control.rising) || timeout_hit;
   assign cnt_clear   = i_control.rising || timeout_hit;
   assign period_en   = in_measure && i_count_enable && !cnt_clear;
   assign high_en     = period_en && high_open_q;

   sat_counter #(.W(CNT_W)) u_period_cnt (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (cnt_clear),
      .i_enable (period_en),
      .o_count  (period_cnt),
      .o_at_max (period_at_max)
   );

   sat_counter #(.W(CNT_W)) u_high_cnt (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (cnt_clear),
      .i_enable (high_en),
      .o_count  (high_cnt),
      .o_at_max (high_at_max)
   );

   // Zero-extend the counters into the full-width result fields.
   always_comb begin
      period_ext              = '0;
      high_ext                = '0;
      period_ext[CNT_W-1:0]   = period_cnt;
      high_ext[CNT_W-1:0]     = high_cnt;
   end

   // Measurement FSM: next state, high-phase tracking, saturation flag and captured record.
   always_comb begin
      state_d     = state_q;
      high_open_d = high_open_q;
      sat_d       = sat_q;
      cap_val     = '0;
      unique case (state_q)
         IDLE: begin
            if (i_control.rising) begin
               state_d     = MEASURE;
               high_open_d = 1'b1;
               sat_d       = 1'b0;
            end
         end
         MEASURE: begin
            if (i_control.rising) begin
               cap_val     = make_meas(period_ext, high_ext, 1'b0, sat_q);
               high_open_d = 1'b1;
               sat_d       = 1'b0;
            end else if (timeout_hit) begin
               cap_val     = make_meas(TIMEOUT_VAL, high_ext, 1'b1, sat_q);
               state_d     = IDLE;
               high_open_d = 1'b0;
               sat_d       = 1'b0;
            end else begin
               // Only the first falling edge matters; later ones find the phase already closed.
               if (i_control.falling) begin
                  high_open_d = 1'b0;
               end
               // Flag any tick lost because a counter is pinned at its maximum.
               if ((period_en && period_at_max) || (high_en && high_at_max)) begin
                  sat_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register: load on capture, drop valid on handshake, flag overwrite of unread data.
   always_comb begin
      result_d  = result_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (capture) begin
         result_d  = cap_val;
         valid_d   = 1'b1;
         overrun_d = valid_q && !i_ready;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         high_open_q <= 1'b0;
         sat_q       <= 1'b0;
         result_q    <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         high_open_q <= high_open_d;
         sat_q       <= sat_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_result  = result_q;
   assign o_valid   = valid_q;
   assign o_overrun = overrun_q;
   assign o_busy    = in_measure;

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: three instances (default width / timeout 10, 4-bit / timeout 14,
// 4-bit with an unreachable timeout) share stimulus; one is selected for checking at a time.
module tb_pulse_measure;
   import pulse_measure_pkg::*;

   logic          clk;
   logic          rst;
   control_path_t ctrl;
   logic          tick;
   logic          rdy;

   measurement_t res_a, res_s, res_h;
   logic         valid_a, valid_s, valid_h;
   logic         ovr_a, ovr_s, ovr_h;
   logic         busy_a, busy_s, busy_h;

   int           sel;
   measurement_t m_res;
   logic         m_valid, m_ovr, m_busy;

   measurement_t s_res;
   logic         s_valid, s_ovr, s_busy;

   measurement_t exp_q[$];
   int           checks;
   int           errors;
   int           ovr_seen;

   typedef struct {
      logic        r, f, t, rdy;
      logic        ev, eb, eo;
      logic        push;
      int unsigned p, h;
   } row_t;

   row_t tbl[15];

   pulse_measure #(.CNT_W(32), .TIMEOUT_TICKS(10)) dut_a (
      .i_clk(clk), .i_reset(rst), .i_control(ctrl), .i_count_enable(tick),
      .o_result(res_a), .o_valid(valid_a), .i_ready(rdy), .o_overrun(ovr_a), .o_busy(busy_a)
   );

   pulse_measure #(.CNT_W(4), .TIMEOUT_TICKS(14)) dut_s (
      .i_clk(clk), .i_reset(rst), .i_control(ctrl), .i_count_enable(tick),
      .o_result(res_s), .o_valid(valid_s), .i_ready(rdy), .o_overrun(ovr_s), .o_busy(busy_s)
   );

   // Timeout beyond the 4-bit range so the counters themselves saturate.
   pulse_measure #(.CNT_W(4), .TIMEOUT_TICKS(20)) dut_h (
      .i_clk(clk), .i_reset(rst), .i_control(ctrl), .i_count_enable(tick),
      .o_result(res_h), .o_valid(valid_h), .i_ready(rdy), .o_overrun(ovr_h), .o_busy(busy_h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Route the selected instance to the checker.
   always_comb begin
      m_res   = res_a;
      m_valid = valid_a;
      m_ovr   = ovr_a;
      m_busy  = busy_a;
      case (sel)
         1: begin m_res = res_s; m_valid = valid_s; m_ovr = ovr_s; m_busy = busy_s; end
         2: begin m_res = res_h; m_valid = valid_h; m_ovr = ovr_h; m_busy = busy_h; end
         default: ;
      endcase
   end

   function automatic row_t mk(input logic r, f, t, rd, ev, eb, eo, push,
                               input int unsigned p, h);
      row_t x;
      x.r = r; x.f = f; x.t = t; x.rdy = rd;
      x.ev = ev; x.eb = eb; x.eo = eo;
      x.push = push; x.p = p; x.h = h;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int unsigned p, h, input logic to, sat);
      exp_q.push_back(make_meas(p, h, to, sat));
   endtask

   // One clock cycle with the given strobes; samples outputs and services the scoreboard mid-cycle.
   task automatic step(input logic r, f, t);
      measurement_t e;
      ctrl.rising  = r;
      ctrl.falling = f;
      tick         = t;
      @(negedge clk);
      s_res   = m_res;
      s_valid = m_valid;
      s_ovr   = m_ovr;
      s_busy  = m_busy;
      if (!rst) begin
         if (m_ovr) begin
            ovr_seen++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL overrun_no_pending: got overrun expected no pending result");
            end else begin
               void'(exp_q.pop_front());
            end
         end
         if (m_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got period=%0d high=%0d expected no result",
                        m_res.period, m_res.high_time);
            end else begin
               e = exp_q.pop_front();
               if (m_res !== e) begin
                  errors++;
                  $display("FAIL sb_result: got p=%0d h=%0d to=%0b sat=%0b expected p=%0d h=%0d to=%0b sat=%0b",
                           m_res.period, m_res.high_time, m_res.timeout, m_res.saturated,
                           e.period, e.high_time, e.timeout, e.saturated);
               end else begin
                  $display("txn dut%0d period=%0d high=%0d timeout=%0b saturated=%0b ok",
                           sel, e.period, e.high_time, e.timeout, e.saturated);
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset(input int new_sel);
      rst = 1'b1;
      sel = new_sel;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      ovr_seen = 0;
      sel      = 0;
      rdy      = 1'b1;
      ctrl     = '0;
      tick     = 1'b0;
      rst      = 1'b1;

      //        r  f  t  rdy ev eb eo push p h
      tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[7]  = mk(0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      tbl[10] = mk(1, 0, 0, 1, 0, 1, 0, 1, 8, 3);
      tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

      // Reset state of every instance.
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_valid_a", valid_a, 0);  chk("rst_busy_a", busy_a, 0);
      chk("rst_ovr_a", ovr_a, 0);      chk("rst_res_a", res_a.period | res_a.high_time, 0);
      chk("rst_valid_s", valid_s, 0);  chk("rst_busy_s", busy_s, 0);
      chk("rst_valid_h", valid_h, 0);  chk("rst_busy_h", busy_h, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic period/high time and a stalled read, cycle by cycle.
      for (int i = 0; i < 15; i++) begin
         rdy = tbl[i].rdy;
         if (tbl[i].push) push_exp(tbl[i].p, tbl[i].h, 1'b0, 1'b0);
         step(tbl[i].r, tbl[i].f, tbl[i].t);
         chk($sformatf("row%0d_valid", i), s_valid, tbl[i].ev);
         chk($sformatf("row%0d_busy", i), s_busy, tbl[i].eb);
         chk($sformatf("row%0d_overrun", i), s_ovr, tbl[i].eo);
      end

      // Overwrite of an unread result, then release.
      rdy = 1'b0;
      ticks(2);
      step(1'b0, 1'b1, 1'b0);
      ticks(6);
      push_exp(8, 2, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      ticks(5);
      push_exp(5, 5, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("ovr_pulse", s_ovr, 1);
      chk("ovr_valid", s_valid, 1);
      chk("ovr_period", s_res.period, 5);
      step(1'b0, 1'b0, 1'b0);
      chk("ovr_once", s_ovr, 0);
      chk("stall_period", s_res.period, 5);
      rdy = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("hs_valid_low", s_valid, 0);

      // Tick coinciding with rising is counted nowhere.
      ticks(4);
      push_exp(4, 4, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      ticks(2);
      push_exp(2, 2, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Timeout after 10 ticks without a rising edge.
      ticks(10);
      push_exp(10, 10, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("to_busy_detect", s_busy, 1);
      step(1'b0, 1'b0, 1'b0);
      chk("to_valid", s_valid, 1);
      chk("to_busy_idle", s_busy, 0);
      ticks(3);
      chk("to_idle_ticks", s_busy, 0);

      // 4-bit counter, timeout 14 reached before saturation.
      do_reset(1);
      step(1'b1, 1'b0, 1'b0);
      push_exp(14, 14, 1'b1, 1'b0);
      ticks(20);
      chk("sat_to_busy", s_busy, 0);
      chk("sat_to_drained", exp_q.size(), 0);

      // 4-bit counter saturation with the high phase open, then with it closed early.
      do_reset(2);
      step(1'b1, 1'b0, 1'b0);
      ticks(18);
      push_exp(15, 15, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      ticks(2);
      step(1'b0, 1'b1, 1'b0);
      ticks(20);
      push_exp(15, 2, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("sat_h_drained", exp_q.size(), 0);

      // Reset in the middle of a measurement discards it.
      do_reset(0);
      step(1'b1, 1'b0, 1'b0);
      ticks(6);
      do_reset(0);
      step(1'b0, 1'b0, 1'b0);
      chk("mid_rst_valid", s_valid, 0);
      chk("mid_rst_busy", s_busy, 0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("post_rst_no_capture", s_valid, 0);
      chk("post_rst_busy", s_busy, 1);
      ticks(3);
      push_exp(3, 3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("post_rst_valid", s_valid, 1);

      chk("queue_empty", exp_q.size(), 0);
      chk("overrun_count", ovr_seen, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
